// File: rtl/kugelblitz_pkg.sv
`default_nettype none
// ============================================================================
// Module   : kugelblitz_pkg
// Purpose  : Shared register map, status bits and capture FSM encoding.
// Revision : 1.0 - initial release
// ============================================================================
package kugelblitz_pkg;

  localparam int CAPTURE_BYTES  = 4;
  localparam int BEAT_BYTE_BITS = 6;   // log2 of bytes per 512-bit beat

  localparam logic [2:0] REG_CTRL      = 3'd0;
  localparam logic [2:0] REG_OFFSET    = 3'd1;
  localparam logic [2:0] REG_STATUS    = 3'd2;
  localparam logic [2:0] REG_DATA      = 3'd3;
  localparam logic [2:0] REG_CAP_COUNT = 3'd4;

  localparam int CTRL_ARM      = 0;
  localparam int CTRL_CONT     = 1;
  localparam int STATUS_VALID  = 0;
  localparam int STATUS_SHORT  = 1;
  localparam int STATUS_ARMED  = 2;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_SOF = 2'd1,
    ST_CAPT     = 2'd2,
    ST_DONE     = 2'd3
  } cap_state_t;

endpackage
`default_nettype wire

// File: rtl/kugelblitz_capture_axil.sv
`default_nettype none
// ============================================================================
// Module   : kugelblitz_capture_axil
// Purpose  : AXI-lite slave handshake and register file for the capture block.
// Revision : 1.0 - initial release
// ============================================================================
module kugelblitz_capture_axil
  import kugelblitz_pkg::*;
#(
  parameter int AXIL_DATA_WIDTH = 32,
  parameter int AXIL_ADDR_WIDTH = 32,
  parameter int AXIL_STRB_WIDTH = AXIL_DATA_WIDTH/8,
  parameter int OFFSET_WIDTH    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [AXIL_ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic [2:0]                 s_axil_awprot,
  input  logic                       s_axil_awvalid,
  output logic                       s_axil_awready,
  input  logic [AXIL_DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [AXIL_STRB_WIDTH-1:0] s_axil_wstrb,
  input  logic                       s_axil_wvalid,
  output logic                       s_axil_wready,
  output logic [1:0]                 s_axil_bresp,
  output logic                       s_axil_bvalid,
  input  logic                       s_axil_bready,
  input  logic [AXIL_ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]                 s_axil_arprot,
  input  logic                       s_axil_arvalid,
  output logic                       s_axil_arready,
  output logic [AXIL_DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]                 s_axil_rresp,
  output logic                       s_axil_rvalid,
  input  logic                       s_axil_rready,
  output logic                       arm,
  output logic                       cont,
  output logic [OFFSET_WIDTH-1:0]    offset,
  input  logic                       clear_arm,
  input  logic                       cap_full,
  input  logic                       cap_short,
  input  logic [AXIL_DATA_WIDTH-1:0] cap_data
);

  logic                       r_awready, r_arready, r_bvalid, r_rvalid;
  logic [AXIL_DATA_WIDTH-1:0] r_rdata;
  logic                       r_arm, r_cont, r_valid, r_short;
  logic [OFFSET_WIDTH-1:0]    r_offset;
  logic [AXIL_DATA_WIDTH-1:0] r_data, r_cap_count;

  logic                       w_wr_en, w_rd_en;
  logic [2:0]                 w_wr_idx, w_rd_idx;
  logic                       w_ctrl_wr, w_status_wr, w_arm_set;
  logic [AXIL_DATA_WIDTH-1:0] w_wmask, w_off_merged, w_rd_word;
  logic                       w_unused;

  assign w_wr_en     = r_awready & s_axil_awvalid & s_axil_wvalid;
  assign w_rd_en     = r_arready & s_axil_arvalid;
  assign w_wr_idx    = s_axil_awaddr[4:2];
  assign w_rd_idx    = s_axil_araddr[4:2];
  assign w_ctrl_wr   = w_wr_en & (w_wr_idx == REG_CTRL) & s_axil_wstrb[0];
  assign w_status_wr = w_wr_en & (w_wr_idx == REG_STATUS) & s_axil_wstrb[0];
  assign w_arm_set   = w_ctrl_wr & s_axil_wdata[CTRL_ARM];

  for (genvar b = 0; b < AXIL_STRB_WIDTH; b++) begin : g_wmask
    assign w_wmask[8*b +: 8] = {8{s_axil_wstrb[b]}};
  end

  assign w_off_merged = ({{(AXIL_DATA_WIDTH-OFFSET_WIDTH){1'b0}}, r_offset} & ~w_wmask)
                      | (s_axil_wdata & w_wmask);

  assign w_unused = &{1'b0, s_axil_awprot, s_axil_arprot, s_axil_awaddr,
                      s_axil_araddr, w_off_merged};

  always_comb begin
    w_rd_word = '0;
    case (w_rd_idx)
      REG_CTRL: begin
        w_rd_word[CTRL_ARM]  = r_arm;
        w_rd_word[CTRL_CONT] = r_cont;
      end
      REG_OFFSET:    w_rd_word[OFFSET_WIDTH-1:0] = r_offset;
      REG_STATUS: begin
        w_rd_word[STATUS_VALID] = r_valid;
        w_rd_word[STATUS_SHORT] = r_short;
        w_rd_word[STATUS_ARMED] = r_arm;
      end
      REG_DATA:      w_rd_word = r_data;
      REG_CAP_COUNT: w_rd_word = r_cap_count;
      default:       w_rd_word = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_awready <= 1'b0;
      r_arready <= 1'b0;
      r_bvalid  <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_awready <= s_axil_awvalid & s_axil_wvalid & ~r_bvalid & ~r_awready;
      r_arready <= s_axil_arvalid & ~r_rvalid & ~r_arready;
      if (r_bvalid && s_axil_bready) r_bvalid <= 1'b0;
      else if (w_wr_en)              r_bvalid <= 1'b1;
      if (w_rd_en) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_word;
      end else if (r_rvalid && s_axil_rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  // Hardware set events take priority over host clears on the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_arm       <= 1'b0;
      r_cont      <= 1'b0;
      r_offset    <= '0;
      r_valid     <= 1'b0;
      r_short     <= 1'b0;
      r_data      <= '0;
      r_cap_count <= '0;
    end else begin
      if (w_arm_set)      r_arm <= 1'b1;
      else if (clear_arm) r_arm <= 1'b0;
      if (w_ctrl_wr) r_cont <= s_axil_wdata[CTRL_CONT];
      if (w_wr_en && (w_wr_idx == REG_OFFSET))
        r_offset <= w_off_merged[OFFSET_WIDTH-1:0];
      if (cap_full) r_valid <= 1'b1;
      else if (w_status_wr && s_axil_wdata[STATUS_VALID]) r_valid <= 1'b0;
      if (cap_short) r_short <= 1'b1;
      else if (w_status_wr && s_axil_wdata[STATUS_SHORT]) r_short <= 1'b0;
      if (cap_full || cap_short) r_data <= cap_data;
      if (cap_full) r_cap_count <= r_cap_count + 1'b1;
    end
  end

  assign s_axil_awready = r_awready;
  assign s_axil_wready  = r_awready;
  assign s_axil_bvalid  = r_bvalid;
  assign s_axil_bresp   = 2'b00;
  assign s_axil_arready = r_arready;
  assign s_axil_rvalid  = r_rvalid;
  assign s_axil_rdata   = r_rdata;
  assign s_axil_rresp   = 2'b00;
  assign arm            = r_arm;
  assign cont           = r_cont;
  assign offset         = r_offset;

endmodule
`default_nettype wire

// File: rtl/kugelblitz_capture.sv
`default_nettype none
// ============================================================================
// Module   : kugelblitz_capture
// Purpose  : Passive AXI-stream tap latching a 4-byte window at a byte offset.
// Revision : 1.0 - initial release
// ============================================================================
module kugelblitz_capture
  import kugelblitz_pkg::*;
#(
  parameter int DATA_WIDTH      = 512,
  parameter int KEEP_WIDTH      = DATA_WIDTH/8,
  parameter int AXIL_DATA_WIDTH = 32,
  parameter int AXIL_ADDR_WIDTH = 32,
  parameter int AXIL_STRB_WIDTH = AXIL_DATA_WIDTH/8,
  parameter int OFFSET_WIDTH    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_WIDTH-1:0]      mon_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]      mon_axis_tkeep,
  input  logic                       mon_axis_tvalid,
  input  logic                       mon_axis_tready,
  input  logic                       mon_axis_tlast,
  input  logic [AXIL_ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic [2:0]                 s_axil_awprot,
  input  logic                       s_axil_awvalid,
  output logic                       s_axil_awready,
  input  logic [AXIL_DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [AXIL_STRB_WIDTH-1:0] s_axil_wstrb,
  input  logic                       s_axil_wvalid,
  output logic                       s_axil_wready,
  output logic [1:0]                 s_axil_bresp,
  output logic                       s_axil_bvalid,
  input  logic                       s_axil_bready,
  input  logic [AXIL_ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]                 s_axil_arprot,
  input  logic                       s_axil_arvalid,
  output logic                       s_axil_arready,
  output logic [AXIL_DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]                 s_axil_rresp,
  output logic                       s_axil_rvalid,
  input  logic                       s_axil_rready,
  output logic                       capture_done
);

  localparam int POS_WIDTH  = OFFSET_WIDTH + 2;
  localparam int BEAT_CNT_W = POS_WIDTH - BEAT_BYTE_BITS;
  localparam int WIN_W      = 8 * CAPTURE_BYTES;

  cap_state_t                r_state, w_state_next;
  logic                      r_in_frame;
  logic [BEAT_CNT_W-1:0]     r_beat_cnt;
  logic [OFFSET_WIDTH-1:0]   r_off_q;
  logic [CAPTURE_BYTES-1:0]  r_got, w_got_d, w_got_acc, w_hit;
  logic [WIN_W-1:0]          r_shadow, w_shadow_d, w_shadow_acc, w_cap_data;
  logic                      r_full, w_full_d;
  logic                      w_latch_off, w_cap_full, w_cap_short, w_clear_arm;
  logic                      w_done_pulse, w_beat, w_base_clr;
  logic                      w_arm, w_cont;
  logic [OFFSET_WIDTH-1:0]   w_offset, w_off_sel;

  kugelblitz_capture_axil #(
    .AXIL_DATA_WIDTH (AXIL_DATA_WIDTH),
    .AXIL_ADDR_WIDTH (AXIL_ADDR_WIDTH),
    .AXIL_STRB_WIDTH (AXIL_STRB_WIDTH),
    .OFFSET_WIDTH    (OFFSET_WIDTH)
  ) u_axil (
    .clk            (clk),
    .rst            (rst),
    .s_axil_awaddr  (s_axil_awaddr),
    .s_axil_awprot  (s_axil_awprot),
    .s_axil_awvalid (s_axil_awvalid),
    .s_axil_awready (s_axil_awready),
    .s_axil_wdata   (s_axil_wdata),
    .s_axil_wstrb   (s_axil_wstrb),
    .s_axil_wvalid  (s_axil_wvalid),
    .s_axil_wready  (s_axil_wready),
    .s_axil_bresp   (s_axil_bresp),
    .s_axil_bvalid  (s_axil_bvalid),
    .s_axil_bready  (s_axil_bready),
    .s_axil_araddr  (s_axil_araddr),
    .s_axil_arprot  (s_axil_arprot),
    .s_axil_arvalid (s_axil_arvalid),
    .s_axil_arready (s_axil_arready),
    .s_axil_rdata   (s_axil_rdata),
    .s_axil_rresp   (s_axil_rresp),
    .s_axil_rvalid  (s_axil_rvalid),
    .s_axil_rready  (s_axil_rready),
    .arm            (w_arm),
    .cont           (w_cont),
    .offset         (w_offset),
    .clear_arm      (w_clear_arm),
    .cap_full       (w_cap_full),
    .cap_short      (w_cap_short),
    .cap_data       (w_cap_data)
  );

  assign w_beat = mon_axis_tvalid & mon_axis_tready;
  // The SOF beat is evaluated against the live OFFSET and an empty window.
  assign w_base_clr = (r_state != ST_CAPT);
  assign w_off_sel  = w_base_clr ? w_offset : r_off_q;

  for (genvar i = 0; i < CAPTURE_BYTES; i++) begin : g_lane
    logic [POS_WIDTH-1:0] w_pos;
    assign w_pos = POS_WIDTH'(w_off_sel) + POS_WIDTH'(i);
    assign w_hit[i] = w_beat && (w_pos[POS_WIDTH-1:BEAT_BYTE_BITS] == r_beat_cnt)
                      && mon_axis_tkeep[w_pos[BEAT_BYTE_BITS-1:0]];
    assign w_got_acc[i] = (~w_base_clr & r_got[i]) | w_hit[i];
    assign w_shadow_acc[8*i +: 8] =
      w_hit[i]   ? mon_axis_tdata[{w_pos[BEAT_BYTE_BITS-1:0], 3'b000} +: 8] :
      w_base_clr ? 8'h00 : r_shadow[8*i +: 8];
  end

  always_comb begin
    w_state_next = r_state;
    w_got_d      = r_got;
    w_shadow_d   = r_shadow;
    w_full_d     = r_full;
    w_latch_off  = 1'b0;
    w_cap_full   = 1'b0;
    w_cap_short  = 1'b0;
    w_clear_arm  = 1'b0;
    w_done_pulse = 1'b0;
    w_cap_data   = r_shadow;
    case (r_state)
      ST_IDLE: if (w_arm) w_state_next = ST_WAIT_SOF;
      ST_WAIT_SOF, ST_CAPT: begin
        if (w_beat && ((r_state == ST_CAPT) || !r_in_frame)) begin
          w_latch_off = (r_state == ST_WAIT_SOF);
          w_got_d     = w_got_acc;
          w_shadow_d  = w_shadow_acc;
          if (&w_got_acc) begin
            w_full_d     = 1'b1;
            w_state_next = ST_DONE;
          end else if (mon_axis_tlast) begin
            w_full_d     = 1'b0;
            w_cap_short  = 1'b1;
            w_cap_data   = w_shadow_acc;
            w_state_next = ST_DONE;
          end else begin
            w_state_next = ST_CAPT;
          end
        end
      end
      ST_DONE: begin
        if (r_full) begin
          w_cap_full   = 1'b1;
          w_done_pulse = 1'b1;
        end
        if (w_cont) begin
          w_state_next = ST_WAIT_SOF;
        end else begin
          w_clear_arm  = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_frame <= 1'b0;
      r_beat_cnt <= '0;
      r_off_q    <= '0;
      r_got      <= '0;
      r_shadow   <= '0;
      r_full     <= 1'b0;
    end else begin
      if (w_beat) begin
        r_in_frame <= ~mon_axis_tlast;
        if (mon_axis_tlast)    r_beat_cnt <= '0;
        else if (~&r_beat_cnt) r_beat_cnt <= r_beat_cnt + 1'b1;
      end
      if (w_latch_off) r_off_q <= w_offset;
      r_got    <= w_got_d;
      r_shadow <= w_shadow_d;
      r_full   <= w_full_d;
    end
  end

  assign capture_done = w_done_pulse;

endmodule
`default_nettype wire

// File: tb/tb_kugelblitz_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_kugelblitz_capture
// Purpose  : Directed and randomized self-checking bench for kugelblitz_capture.
// Revision : 1.0 - initial release
// ============================================================================
module tb_kugelblitz_capture;

  localparam logic [31:0] A_CTRL = 32'h00, A_OFF = 32'h04, A_STAT = 32'h08;
  localparam logic [31:0] A_DATA = 32'h0C, A_CNT = 32'h10, A_NONE = 32'h18;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [511:0] mon_axis_tdata = '0;
  logic [63:0]  mon_axis_tkeep = '0;
  logic         mon_axis_tvalid = 1'b0, mon_axis_tready = 1'b1, mon_axis_tlast = 1'b0;
  logic [31:0]  s_axil_awaddr = '0, s_axil_wdata = '0, s_axil_araddr = '0, s_axil_rdata;
  logic [2:0]   s_axil_awprot = '0, s_axil_arprot = '0;
  logic [3:0]   s_axil_wstrb = '0;
  logic         s_axil_awvalid = 1'b0, s_axil_wvalid = 1'b0, s_axil_arvalid = 1'b0;
  logic         s_axil_bready = 1'b1, s_axil_rready = 1'b1;
  logic         s_axil_awready, s_axil_wready, s_axil_bvalid, s_axil_arready, s_axil_rvalid;
  logic [1:0]   s_axil_bresp, s_axil_rresp;
  logic         capture_done;

  kugelblitz_capture dut (
    .clk(clk), .rst(rst),
    .mon_axis_tdata(mon_axis_tdata), .mon_axis_tkeep(mon_axis_tkeep),
    .mon_axis_tvalid(mon_axis_tvalid), .mon_axis_tready(mon_axis_tready),
    .mon_axis_tlast(mon_axis_tlast),
    .s_axil_awaddr(s_axil_awaddr), .s_axil_awprot(s_axil_awprot),
    .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
    .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
    .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
    .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid),
    .s_axil_bready(s_axil_bready),
    .s_axil_araddr(s_axil_araddr), .s_axil_arprot(s_axil_arprot),
    .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
    .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
    .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
    .capture_done(capture_done)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int done_cnt = 0;
  always @(negedge clk) if (capture_done === 1'b1) done_cnt++;

  // Reference state: the frame as a flat byte array plus expected register contents.
  logic [7:0]  fb [0:511];
  bit          fk [0:511];
  int          fbeats;
  logic [31:0] exp_data = '0, exp_count = '0;
  int          exp_done = 0;
  bit          exp_valid = 0, exp_short = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, want);
    end
  endtask

  task automatic axil_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    bit to;
    to = 0;
    @(negedge clk);
    s_axil_awaddr = a; s_axil_wdata = d; s_axil_wstrb = s;
    s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!(s_axil_awready && s_axil_wready) && n < 20);
    if (n >= 20) to = 1;
    @(posedge clk); #1;
    s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!s_axil_bvalid && n < 20);
    if (n >= 20) to = 1;
    check("axil_wr_timeout", {31'b0, to}, 32'd0);
    check("axil_bresp", {30'b0, s_axil_bresp}, 32'd0);
  endtask

  task automatic axil_read(input logic [31:0] a, output logic [31:0] d);
    int n;
    bit to;
    to = 0;
    @(negedge clk);
    s_axil_araddr = a; s_axil_arvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!s_axil_arready && n < 20);
    if (n >= 20) to = 1;
    @(posedge clk); #1;
    s_axil_arvalid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!s_axil_rvalid && n < 20);
    if (n >= 20) to = 1;
    d = s_axil_rdata;
    check("axil_rd_timeout", {31'b0, to}, 32'd0);
  endtask

  task automatic rd_check(input string tag, input logic [31:0] a, input logic [31:0] want);
    logic [31:0] v;
    axil_read(a, v);
    check(tag, v, want);
  endtask

  // mode 0: byte k = k, mode 1: byte k = k+0x80, mode 2: random bytes
  task automatic fill_frame(input int nbeats, input int last_bytes, input int mode);
    fbeats = nbeats;
    for (int k = 0; k < 512; k++) begin
      fb[k] = (mode == 0) ? 8'(k) : (mode == 1) ? 8'(k + 8'h80) : 8'($urandom);
      fk[k] = (k < (nbeats - 1) * 64 + last_bytes);
    end
  endtask

  task automatic send_beat(input int b);
    @(negedge clk);
    for (int j = 0; j < 64; j++) begin
      mon_axis_tdata[8*j +: 8] = fb[b*64 + j];
      mon_axis_tkeep[j]        = fk[b*64 + j];
    end
    mon_axis_tlast = (b == fbeats - 1);
    mon_axis_tvalid = 1'b1; mon_axis_tready = 1'b1;
  endtask

  // A presented but not-accepted beat carrying junk and tlast.
  task automatic stall_beat();
    @(negedge clk);
    for (int j = 0; j < 16; j++) mon_axis_tdata[32*j +: 32] = $urandom;
    mon_axis_tkeep = '1; mon_axis_tlast = 1'b1;
    mon_axis_tvalid = 1'b1; mon_axis_tready = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      mon_axis_tvalid = 1'b0; mon_axis_tlast = 1'b0; mon_axis_tready = 1'b1;
    end
  endtask

  task automatic send_frame(input int stall_at, input bit gaps);
    for (int b = 0; b < fbeats; b++) begin
      if (b == stall_at) stall_beat();
      send_beat(b);
      if (gaps && $urandom_range(0, 1) == 1) idle(1);
    end
    idle(1);
  endtask

  // Window byte i is frame byte off+i when that byte exists and is kept.
  task automatic model(input int off, output logic [31:0] d, output bit full);
    int got;
    got = 0; d = '0;
    for (int i = 0; i < 4; i++) begin
      int p;
      p = off + i;
      if (p < fbeats * 64) begin
        if (fk[p]) begin d[8*i +: 8] = fb[p]; got++; end
      end
    end
    full = (got == 4);
  endtask

  task automatic expect_capture(input string tag, input int off, input bit armed_after);
    logic [31:0] d;
    bit full;
    model(off, d, full);
    exp_data = d;
    if (full) begin exp_count++; exp_done++; exp_valid = 1; end
    else exp_short = 1;
    idle(4);
    rd_check({tag, "_data"}, A_DATA, exp_data);
    rd_check({tag, "_status"}, A_STAT, {29'b0, armed_after, exp_short, exp_valid});
    rd_check({tag, "_count"}, A_CNT, exp_count);
    check({tag, "_done"}, done_cnt, exp_done);
  endtask

  task automatic clear_status();
    axil_write(A_STAT, 32'h3, 4'hF);
    exp_valid = 0; exp_short = 0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_outs", {24'b0, s_axil_awready, s_axil_wready, s_axil_bvalid, s_axil_arready,
                       s_axil_rvalid, capture_done, s_axil_bresp != 2'b00, s_axil_rresp != 2'b00}, 32'd0);
    check("rst_rdata", s_axil_rdata, 32'd0);
    @(negedge clk) rst = 1'b0;

    rd_check("rst_ctrl", A_CTRL, 32'd0);
    rd_check("rst_off", A_OFF, 32'd0);
    rd_check("rst_stat", A_STAT, 32'd0);
    rd_check("rst_data", A_DATA, 32'd0);
    rd_check("rst_cnt", A_CNT, 32'd0);
    rd_check("unmapped", A_NONE, 32'd0);

    axil_write(A_OFF, 32'h1234, 4'hF);
    axil_write(A_OFF, 32'hABCD, 4'h1);
    rd_check("wstrb_off", A_OFF, 32'h12CD);
    axil_write(A_DATA, 32'hDEADBEEF, 4'hF);
    rd_check("ro_data", A_DATA, 32'd0);

    // Aligned window in beat 0
    axil_write(A_OFF, 32'h10, 4'hF);
    axil_write(A_CTRL, 32'h1, 4'hF);
    fill_frame(2, 64, 0);
    send_frame(-1, 0);
    expect_capture("t1", 16, 0);
    rd_check("t1_ctrl", A_CTRL, 32'd0);

    // Window straddling beats 0 and 1
    clear_status();
    axil_write(A_OFF, 32'd62, 4'hF);
    axil_write(A_CTRL, 32'h1, 4'hF);
    fill_frame(2, 64, 0);
    send_frame(-1, 0);
    expect_capture("t2", 62, 0);

    // Offset beyond the frame
    clear_status();
    axil_write(A_OFF, 32'd100, 4'hF);
    axil_write(A_CTRL, 32'h1, 4'hF);
    fill_frame(1, 64, 0);
    send_frame(-1, 0);
    expect_capture("t3", 100, 0);

    // Armed mid-frame: the in-progress frame is skipped
    clear_status();
    axil_write(A_OFF, 32'd0, 4'hF);
    fill_frame(3, 64, 1);
    send_beat(0);
    idle(1);
    axil_write(A_CTRL, 32'h1, 4'hF);
    send_beat(1);
    send_beat(2);
    idle(3);
    rd_check("t4_skip_stat", A_STAT, 32'h4);
    rd_check("t4_skip_cnt", A_CNT, exp_count);
    fill_frame(1, 64, 0);
    send_frame(-1, 0);
    expect_capture("t4", 0, 0);

    // Continuous mode with a stalled beat inside frame 2
    clear_status();
    axil_write(A_OFF, 32'd70, 4'hF);
    axil_write(A_CTRL, 32'h3, 4'hF);
    fill_frame(3, 64, 2); send_frame(-1, 1); expect_capture("t5f1", 70, 1);
    fill_frame(3, 64, 2); send_frame(1, 0);  expect_capture("t5f2", 70, 1);
    fill_frame(3, 64, 2); send_frame(0, 1);  expect_capture("t5f3", 70, 1);
    axil_write(A_CTRL, 32'h0, 4'hF);
    rd_check("t5_ctrl_still_armed", A_CTRL, 32'h1);
    fill_frame(2, 64, 2); send_frame(-1, 0); expect_capture("t5f4", 70, 0);
    rd_check("t5_ctrl_disarmed", A_CTRL, 32'h0);

    // Randomized frames, offsets, tkeep tails and stalls
    for (int it = 0; it < 16; it++) begin
      int off, nb, lb;
      off = $urandom_range(0, 270);
      nb  = $urandom_range(1, 4);
      lb  = $urandom_range(1, 64);
      clear_status();
      axil_write(A_OFF, 32'(off), 4'hF);
      axil_write(A_CTRL, 32'h1, 4'hF);
      fill_frame(nb, lb, 2);
      send_frame($urandom_range(0, nb), 1);
      expect_capture($sformatf("rnd%0d", it), off, 0);
    end

    // Reset in the middle of a capture
    clear_status();
    axil_write(A_OFF, 32'd130, 4'hF);
    axil_write(A_CTRL, 32'h3, 4'hF);
    fill_frame(3, 64, 2);
    send_beat(0);
    send_beat(1);
    @(negedge clk);
    rst = 1'b1; mon_axis_tvalid = 1'b0; mon_axis_tlast = 1'b0;
    #1;
    check("t6_rst_outs", {26'b0, s_axil_awready, s_axil_bvalid, s_axil_arready,
                          s_axil_rvalid, capture_done, 1'b0}, 32'd0);
    @(negedge clk) rst = 1'b0;
    exp_count = '0; exp_data = '0; exp_valid = 0; exp_short = 0;
    rd_check("t6_ctrl", A_CTRL, 32'd0);
    rd_check("t6_off", A_OFF, 32'd0);
    rd_check("t6_stat", A_STAT, 32'd0);
    rd_check("t6_data", A_DATA, 32'd0);
    rd_check("t6_cnt", A_CNT, 32'd0);
    fill_frame(3, 64, 2);
    send_frame(-1, 0);
    idle(4);
    rd_check("t6_post_stat", A_STAT, 32'd0);
    rd_check("t6_post_cnt", A_CNT, 32'd0);
    rd_check("t6_post_data", A_DATA, 32'd0);
    check("t6_post_done", done_cnt, exp_done);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
